// File: rtl/serial_tx_pkg.sv
// Shared types and line levels for the serial_tx_1b_line transmitter.
// SERIAL_TX_PARITY_EN adds the PARITY state to the state enum.
package serial_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3
`ifdef SERIAL_TX_PARITY_EN
    ,
    ST_PARITY = 3'd4
`endif
  } state_t;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/serial_tx_1b_line_if.sv
// Word handshake into the serial transmitter.
// Valid/ready: a word moves on a posedge where in_val && in_rdy; in_rdy never depends on in_val.
interface serial_tx_1b_line_if #(parameter int NBITS = 8);
  logic             in_val;
  logic             in_rdy;
  logic [NBITS-1:0] in_msg;

  modport master (output in_val, output in_msg, input in_rdy);
  modport slave  (input in_val, input in_msg, output in_rdy);
endinterface

// File: rtl/serial_tx_shreg.sv
// Load / shift-right register feeding data bits LSB first to the line flop.
module serial_tx_shreg #(
  parameter int NBITS = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [NBITS-1:0] din,
  output logic             lsb
);

  logic [NBITS-1:0] q;

  // load wins over shift so a back-to-back word is never corrupted
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= {1'b0, q[NBITS-1:1]};
    end
  end

  assign lsb = q[0];

endmodule

// File: rtl/serial_tx_1b_line.sv
// Framed 1-bit serial transmitter: start(0), NBITS data LSB first, optional even parity, stop(1).
// Define SERIAL_TX_PARITY_EN to insert the parity bit between data and stop.
module serial_tx_1b_line
  import serial_tx_pkg::*;
#(
  parameter int NBITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  serial_tx_1b_line_if.slave  in_if,
  output logic                out,
  output logic                busy,
  output state_t              dbg_state
);

  localparam int CW = $clog2(NBITS);
  localparam logic [CW-1:0] LAST_BIT = CW'(NBITS - 1);

  state_t        state;
  logic [CW-1:0] bit_cnt;
  logic          xfer;
  logic          shift;
  logic          data_lsb;

  assign in_if.in_rdy = !reset && (state == ST_IDLE || state == ST_STOP);
  assign xfer         = in_if.in_val && in_if.in_rdy;
  assign shift        = (state == ST_START) || (state == ST_DATA);
  assign busy         = (state != ST_IDLE);
  assign dbg_state    = state;

  serial_tx_shreg #(.NBITS(NBITS)) u_shreg (
    .clk   (clk),
    .reset (reset),
    .load  (xfer),
    .shift (shift),
    .din   (in_if.in_msg),
    .lsb   (data_lsb)
  );

`ifdef SERIAL_TX_PARITY_EN
  logic parity;

  always_ff @(posedge clk) begin
    if (reset) begin
      parity <= 1'b0;
    end else if (xfer) begin
      parity <= ^in_if.in_msg;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      out     <= IDLE_LEVEL;
      bit_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_STOP: begin
          if (xfer) begin
            state <= ST_START;
            out   <= START_BIT;
          end else begin
            state <= ST_IDLE;
            out   <= IDLE_LEVEL;
          end
        end
        ST_START: begin
          state   <= ST_DATA;
          out     <= data_lsb;
          bit_cnt <= '0;
        end
        ST_DATA: begin
          if (bit_cnt == LAST_BIT) begin
            bit_cnt <= '0;
`ifdef SERIAL_TX_PARITY_EN
            state   <= ST_PARITY;
            out     <= parity;
`else
            state   <= ST_STOP;
            out     <= STOP_BIT;
`endif
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
            out     <= data_lsb;
          end
        end
`ifdef SERIAL_TX_PARITY_EN
        ST_PARITY: begin
          state <= ST_STOP;
          out   <= STOP_BIT;
        end
`endif
        default: begin
          state   <= ST_IDLE;
          out     <= IDLE_LEVEL;
          bit_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx_1b_line.sv
// Self-checking bench for serial_tx_1b_line (NBITS=8), either build of SERIAL_TX_PARITY_EN.
module tb_serial_tx_1b_line;
  import serial_tx_pkg::*;

  localparam int NBITS = 8;
`ifdef SERIAL_TX_PARITY_EN
  localparam int FLEN = 11;
  localparam logic [15:0] LIT_A5 = 16'b00000_10101001010;
  localparam logic [15:0] LIT_0F = 16'b00000_10000011110;
  localparam logic [15:0] LIT_96 = 16'b00000_10100101100;
  localparam logic P01 = 1'b1;
  localparam logic PFF = 1'b0;
`else
  localparam int FLEN = 10;
  localparam logic [15:0] LIT_A5 = 16'b000000_1101001010;
  localparam logic [15:0] LIT_0F = 16'b000000_1000011110;
  localparam logic [15:0] LIT_96 = 16'b000000_1100101100;
  localparam logic P01 = 1'b1;
  localparam logic PFF = 1'b1;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  serial_tx_1b_line_if #(.NBITS(NBITS)) bus ();
  logic   out;
  logic   busy;
  state_t dbg_state;

  serial_tx_1b_line #(.NBITS(NBITS)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_if     (bus.slave),
    .out       (out),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // model: line is a queue of pending bits; ready whenever nothing is pending
  logic [0:0] exp_q[$];
  logic       m_out   = 1'b1;
  logic       m_frame = 1'b0;
  bit         m_valid = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
    if (reset) begin
      exp_q.delete();
      m_out   = 1'b1;
      m_frame = 1'b0;
      m_valid = 1'b1;
    end else begin
      if (m_valid && bus.in_val && exp_q.size() == 0) begin
        exp_q.push_back(1'b0);
        for (int i = 0; i < NBITS; i++) exp_q.push_back(bus.in_msg[i]);
`ifdef SERIAL_TX_PARITY_EN
        exp_q.push_back(^bus.in_msg);
`endif
        exp_q.push_back(1'b1);
      end
      if (exp_q.size() > 0) begin
        m_out   = exp_q.pop_front();
        m_frame = 1'b1;
      end else begin
        m_out   = 1'b1;
        m_frame = 1'b0;
      end
    end
  end

  // scoreboard compare on every negedge once reset has been seen
  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      check("out", out, m_out);
      check("busy", busy, m_frame);
      check("in_rdy", bus.in_rdy, (!reset && exp_q.size() == 0));
    end
  end

  // driver tasks
  task automatic send_word(input logic [7:0] d, input bit keep);
    bit ok;
    ok = 1'b0;
    bus.in_msg = d;
    bus.in_val = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_rdy) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!keep) bus.in_val = 1'b0;
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: word %0h got no ready expected ready within 50 cycles", d);
    end
  endtask

  task automatic collect(input int n, output logic [15:0] seq);
    seq = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      seq[i] = out;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] seq;
    int t_a, t_b;
    bus.in_val = 1'b0;
    bus.in_msg = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // idle line
    repeat (20) begin
      @(negedge clk);
      check("idle_out", out, 1'b1);
      check("idle_busy", busy, 1'b0);
      check("idle_rdy", bus.in_rdy, 1'b1);
    end

    // single frame 0xA5
    send_word(8'hA5, 1'b0);
    collect(FLEN, seq);
    check("frame_a5", seq, LIT_A5);
    @(negedge clk);
    check("after_a5_out", out, 1'b1);
    check("after_a5_busy", busy, 1'b0);

    // parity / stop position after msb
    send_word(8'h01, 1'b0);
    collect(FLEN, seq);
    check("bit9_01", seq[9], P01);
    check("last_01", seq[FLEN-1], 1'b1);
    send_word(8'hFF, 1'b0);
    collect(FLEN, seq);
    check("bit9_ff", seq[9], PFF);
    check("last_ff", seq[FLEN-1], 1'b1);
    repeat (2) @(negedge clk);

    // back-to-back frames with in_val held high
    send_word(8'h3C, 1'b1);
    t_a = cyc;
    send_word(8'hC3, 1'b0);
    t_b = cyc;
    check("b2b_gap", t_b - t_a, FLEN);
    repeat (FLEN + 2) @(negedge clk);

    // reset during the 4th data bit of 0x5A
    send_word(8'h5A, 1'b0);
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort_out", out, 1'b1);
    check("abort_busy", busy, 1'b0);
    send_word(8'h0F, 1'b0);
    collect(FLEN, seq);
    check("frame_0f", seq, LIT_0F);

    // in_val pulse while not ready must be ignored
    repeat (2) @(negedge clk);
    send_word(8'h96, 1'b0);
    fork
      collect(FLEN, seq);
      begin
        repeat (3) @(posedge clk);
        #1;
        bus.in_val = 1'b1;
        bus.in_msg = 8'h77;
        @(posedge clk);
        #1;
        bus.in_val = 1'b0;
      end
    join
    check("frame_96", seq, LIT_96);
    repeat (3) begin
      @(negedge clk);
      check("stall_idle_out", out, 1'b1);
      check("stall_idle_busy", busy, 1'b0);
    end

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
